// File: rtl/stack_cmd_sequencer.sv
// Sequences push/pop/get requests onto a downstream stack with one-cycle command issue.
// Latency: 2 cycles accept-to-response for a stack op, 1 cycle for nop/illegal; no response backpressure.
module stack_cmd_sequencer #(
    parameter int DEPTH = 5,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_data,
    input  logic [2:0]       req_index,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic [1:0]       stk_command,
    output logic [2:0]       stk_index,
    output logic [WIDTH-1:0] stk_wdata,
    input  logic [WIDTH-1:0] stk_rdata,
    output logic             stk_reset,
    output logic [2:0]       count,
    output logic             full,
    output logic             empty
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [2:0] DEPTH_C = 3'(DEPTH);

    state_t           state_q, state_d;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic [2:0]       idx_q;
    logic [2:0]       count_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_err_q;

    logic             accept;
    logic             legal;
    logic [2:0]       idx_mod;

    assign count     = count_q;
    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == 3'd0);
    assign stk_reset = ~reset;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign accept    = req_valid && req_ready;
    assign idx_mod   = (req_index >= DEPTH_C) ? (req_index - DEPTH_C) : req_index;

    // Legality is judged on the occupancy seen at the accept edge.
    always_comb begin
        legal = 1'b0;
        case (req_op)
            OP_PUSH: legal = !full;
            OP_POP:  legal = !empty;
            2'b11:   legal = (idx_mod < count_q);
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (legal && req_op != OP_NOP) ? ISSUE : RESP;
            ISSUE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Stack command is a pure decode of ISSUE so an async reset drops it at once.
    always_comb begin
        req_ready   = (state_q == IDLE) && reset;
        rsp_valid   = (state_q == RESP);
        stk_command = 2'b00;
        stk_index   = 3'd0;
        stk_wdata   = '0;
        if (state_q == ISSUE) begin
            stk_command = op_q;
            stk_index   = idx_q;
            stk_wdata   = data_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q       <= OP_NOP;
            data_q     <= '0;
            idx_q      <= 3'd0;
            count_q    <= 3'd0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            if (accept) begin
                op_q   <= req_op;
                data_q <= req_data;
                idx_q  <= req_index;
                if (!(legal && req_op != OP_NOP)) begin
                    rsp_err_q  <= (req_op != OP_NOP);
                    rsp_data_q <= '0;
                end
            end
            if (state_q == ISSUE) begin
                rsp_err_q  <= 1'b0;
                rsp_data_q <= (op_q == OP_PUSH) ? '0 : stk_rdata;
                if (op_q == OP_PUSH) begin
                    count_q <= count_q + 3'd1;
                end else if (op_q == OP_POP) begin
                    count_q <= count_q - 3'd1;
                end
            end
        end
    end

endmodule
